// File: rtl/brick_hit_scanner.sv
// brick_hit_scanner: scans the brick table for the first live brick under the ball and retires it.
//
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   start_i            one-cycle scan request, accepted only while idle
//   ball_x_i/ball_y_i  ball top-left pixel, latched on an accepted start
//   busy_o             high whenever a scan is in progress
//   done_o             one-cycle pulse at the end of a scan
//   hit_o, hit_*_o     result of the last scan; held until the next accepted start
//   ram_addr_o         brick RAM address
//   ram_rdata_i        brick RAM read data (one cycle after address)
//   ram_wdata_o        brick RAM write data
//   ram_wren_o         brick RAM write enable
module brick_hit_scanner #(
    parameter int NUM_BRICKS = 40,
    parameter int ADDR_W     = 7,
    parameter int BRICK_W    = 16,
    parameter int BRICK_H    = 4,
    parameter int BALL_SIZE  = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start_i,
    input  logic [7:0]        ball_x_i,
    input  logic [6:0]        ball_y_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              hit_o,
    output logic [7:0]        hit_x_o,
    output logic [6:0]        hit_y_o,
    output logic [2:0]        hit_colour_o,
    output logic [5:0]        hit_index_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    input  logic [17:0]       ram_rdata_i,
    output logic [17:0]       ram_wdata_o,
    output logic              ram_wren_o
);
    typedef enum logic [2:0] {IDLE, READ, CHECK, CLEAR, DONE} state_t;

    state_t            state_q;
    logic [7:0]        ball_x_q;
    logic [6:0]        ball_y_q;
    logic [5:0]        idx_q;
    logic              hit_q;
    logic [7:0]        hit_x_q;
    logic [6:0]        hit_y_q;
    logic [2:0]        hit_colour_q;
    logic [5:0]        hit_index_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [17:0]       ram_wdata_q;

    // 9-bit compares so a brick or ball near the right edge cannot wrap
    logic [8:0] bx, by, px, py;
    logic       live, overlap, last;

    assign bx      = {1'b0, ram_rdata_i[7:0]};
    assign by      = {2'b0, ram_rdata_i[14:8]};
    assign px      = {1'b0, ball_x_q};
    assign py      = {2'b0, ball_y_q};
    assign live    = |ram_rdata_i[17:15];
    assign overlap = live && (px + 9'(BALL_SIZE) > bx) && (px < bx + 9'(BRICK_W))
                          && (py + 9'(BALL_SIZE) > by) && (py < by + 9'(BRICK_H));
    assign last    = idx_q == 6'(NUM_BRICKS - 1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            ball_x_q     <= '0;
            ball_y_q     <= '0;
            idx_q        <= '0;
            hit_q        <= 1'b0;
            hit_x_q      <= '0;
            hit_y_q      <= '0;
            hit_colour_q <= '0;
            hit_index_q  <= '0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    ball_x_q   <= ball_x_i;
                    ball_y_q   <= ball_y_i;
                    idx_q      <= '0;
                    ram_addr_q <= '0;
                    hit_q      <= 1'b0;
                    state_q    <= READ;
                end
                READ: state_q <= CHECK;
                CHECK: begin
                    if (overlap) begin
                        hit_x_q      <= ram_rdata_i[7:0];
                        hit_y_q      <= ram_rdata_i[14:8];
                        hit_colour_q <= ram_rdata_i[17:15];
                        hit_index_q  <= idx_q;
                        ram_wdata_q  <= {3'b000, ram_rdata_i[14:0]};
                        ram_addr_q   <= ADDR_W'(idx_q);
                        state_q      <= CLEAR;
                    end else if (last) begin
                        state_q <= DONE;
                    end else begin
                        idx_q      <= idx_q + 6'd1;
                        ram_addr_q <= ADDR_W'(idx_q + 6'd1);
                        state_q    <= READ;
                    end
                end
                CLEAR: begin
                    hit_q   <= 1'b1;
                    state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Write enable comes straight from the state so a reset landing on CLEAR still writes
    assign ram_wren_o   = state_q == CLEAR;
    assign busy_o       = state_q != IDLE;
    assign done_o       = state_q == DONE;
    assign hit_o        = hit_q;
    assign hit_x_o      = hit_x_q;
    assign hit_y_o      = hit_y_q;
    assign hit_colour_o = hit_colour_q;
    assign hit_index_o  = hit_index_q;
    assign ram_addr_o   = ram_addr_q;
    assign ram_wdata_o  = ram_wdata_q;
endmodule
